l2_cache_assoc: RTL
===================

Name: l2_cache_assoc

Overview:
- Parametrised set-associative, word-granular L2 cache (one 32-bit word per entry); successor to the fixed 8-way L2 cache.
- Adds configurable way count and set depth, per-set round-robin victim selection and miss allocation on full-word fills.
- Adds a sequential flush engine (also run after reset) with a Busy flag, and registered lookups.
- Sits between the CPU-side read path (RDA/RDD/Match) and the write/fill snoop path from the bus controller.

Parameters:
- WAYS, 8, number of ways (power of 2, 2..16).
- SET_BITS, 6, log2 of the number of sets; index = address[SET_BITS+1:2].
- ADDR_HI, 27, top address bit; tag = address[ADDR_HI:SET_BITS+2].

Ports:
- CLK  in  1  system clock.
- nRES  in  1  asynchronous active-low reset.
- CPUCLKr  in  1  write-side qualifier; TS/WR/CLR are sampled only on cycles with CPUCLKr=1.
- RDA  in  ADDR_HI-1  lookup address [ADDR_HI:2], sampled every cycle.
- RDD  out  32  lookup data, registered.
- Match  out  1  lookup hit, registered.
- Busy  out  1  flush engine active.
- WRA  in  ADDR_HI-1  write/fill/invalidate address [ADDR_HI:2].
- WRD  in  32  write/fill data.
- WRM  in  4  byte mask; WRM[0] covers WRD[7:0].
- TS  in  1  fill (tag store) strobe.
- WR  in  1  write-snoop strobe.
- CLR  in  1  invalidate strobe.
- ALL  in  1  with CLR, flush the whole cache.

Behaviour:
- Reset (nRES=0): Match=0, RDD=0, Busy=1, FSM=FLUSH, flush counter=0, all RR pointers=0. Reset asserted mid-flush restarts the flush from set 0.
- FSM states: IDLE and FLUSH.
  - FLUSH clears the valid bits of all ways in set[counter], one set per cycle; counter increments.
  - At counter = 2^SET_BITS-1, FLUSH -> IDLE next cycle. A flush therefore takes exactly 2^SET_BITS cycles with Busy=1.
  - Busy=0 in IDLE.
- Lookup: RDA in cycle N produces Match/RDD valid in cycle N+1 (latency 1).
  - Hit: a way has its valid bit set and its tag equal.
  - Multiple hits (illegal): the lowest-numbered way wins.
  - Miss, or Busy=1: Match=0 and RDD=0.
- Write-side priority (CPUCLKr=1, IDLE only): CLR&ALL > CLR > TS > WR. All strobes are ignored while Busy.
  - CLR&ALL: enter FLUSH at counter 0.
  - CLR only: clear the valid bit of any way hitting WRA.
  - TS, hit: byte-merge WRD into the hit way per WRM; no replacement.
  - TS, miss with WRM=4'hF: allocate a way, write tag and data, set valid.
    - Victim = lowest invalid way in the set; if none are invalid, the set's RR pointer.
    - The RR pointer increments (mod WAYS) only when the pointer itself was used as the victim.
  - TS, miss with a partial WRM: no allocation, no state change.
  - WR, hit: byte-merge WRD per WRM. WR, miss: no allocation.
- A same-cycle lookup and write to the same entry returns the pre-write contents (no bypass); the new data is visible to a lookup issued the following cycle.
- The TS/WR/CLR compare uses current array state; a read-modify-write completes within one cycle.

Decomposition:
- Shared package l2_cache_pkg holds:
  - FSM state encoding (IDLE, FLUSH).
  - Write-op priority encoding.
  - Byte-merge function merge(old, new, mask).
  - Tag/index width derivation functions from ADDR_HI and SET_BITS.
- Sub-module l2_cache_assoc_way, instantiated WAYS times:
  - Tag/data storage (inferable RAM), valid-bit vector, read compare, write port.
  - Per-way outputs: hit and data.
- Top level holds the hit mux, victim selection, RR pointer array and flush FSM.

Test Plan:
- Reset release (WAYS=8, SET_BITS=6) -> Busy=1 for exactly 64 cycles, then Busy=0; all lookups miss with RDD=0 throughout.
- TS WRA=0x0000040, WRD=0xDEADBEEF, WRM=F; lookup RDA=0x0000040 next cycle -> Match=1, RDD=0xDEADBEEF one cycle later.
- WR to the same address with WRD=0x11223344, WRM=4'b0011 -> subsequent lookup returns RDD=0xDEAD3344. WR to an uncached address -> later lookup misses.
- Nine full-word fills to nine distinct tags in set 5 -> ways 0..7 fill in order; the ninth evicts way 0 and its tag misses. A tenth fill evicts way 1.
- CLR on a single cached address -> that address misses, a neighbour in the same set still hits. CLR&ALL -> Busy=1 for 64 cycles and TS during Busy is dropped (later lookup misses).
- TS with CPUCLKr=0 -> no effect. TS with partial mask to a missing address -> no allocation. nRES pulse at flush counter 30 -> flush restarts and Busy lasts another 64 cycles.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// ---------------------------------------------------------------------------
// l2_cache_pkg
// Shared definitions for the set-associative L2 cache: flush FSM states,
// write-side operation encoding, byte-merge helper and address field widths.
// ---------------------------------------------------------------------------
package l2_cache_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    // Write-side operations, one per cycle, chosen by strobe priority.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_FLUSH_ALL,
        OP_CLR,
        OP_FILL,
        OP_WRITE
    } wr_op_t;

    // Address is carried as [ADDR_HI:2]; tag is everything above the index.
    function automatic int tag_width(input int addr_hi, input int set_bits);
        return addr_hi - set_bits - 1;
    endfunction

    function automatic int addr_width(input int addr_hi);
        return addr_hi - 1;
    endfunction

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [31:0] merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // CLR&ALL > CLR > TS > WR.
    function automatic wr_op_t decode_op(input logic ts, input logic wr,
                                         input logic clr, input logic all);
        if (clr && all) return OP_FLUSH_ALL;
        if (clr)        return OP_CLR;
        if (ts)         return OP_FILL;
        if (wr)         return OP_WRITE;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/l2_cache_assoc_way.sv
// ---------------------------------------------------------------------------
// l2_cache_assoc_way
// One way of the L2 cache: tag RAM, data RAM and per-set valid bits.
// Two combinational compare ports (lookup and write side) and one write port.
//   clk                     : clock
//   rd_idx/rd_tag           : lookup set and tag   -> rd_hit, rd_data
//   wr_idx/wr_tag           : write-side set, tag  -> wr_hit, wr_valid
//   wr_data/wr_mask         : fill/merge data and byte mask
//   merge_en/alloc_en/clr_en: byte-merge hit, allocate entry, invalidate
//   flush_en/flush_idx      : clear the valid bit of one set
// ---------------------------------------------------------------------------
module l2_cache_assoc_way
    import l2_cache_pkg::*;
#(
    parameter int SET_BITS = 6,
    parameter int TAG_W    = 20
) (
    input  logic                clk,
    input  logic [SET_BITS-1:0] rd_idx,
    input  logic [TAG_W-1:0]    rd_tag,
    output logic                rd_hit,
    output logic [31:0]         rd_data,
    input  logic [SET_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [31:0]         wr_data,
    input  logic [3:0]          wr_mask,
    input  logic                merge_en,
    input  logic                alloc_en,
    input  logic                clr_en,
    input  logic                flush_en,
    input  logic [SET_BITS-1:0] flush_idx,
    output logic                wr_hit,
    output logic                wr_valid
);

    localparam int SETS = 1 << SET_BITS;

    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [31:0]       data_mem [SETS];
    logic [SETS-1:0]   valid;

    assign rd_hit   = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data  = data_mem[rd_idx];
    assign wr_valid = valid[wr_idx];
    assign wr_hit   = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    // NOTE: storage arrays carry no reset so they map onto RAM; the flush
    // engine that runs after every reset is what makes their contents safe.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end else if (merge_en) begin
            data_mem[wr_idx] <= merge(data_mem[wr_idx], wr_data, wr_mask);
        end
    end

    // Flush and write-side ops never coincide: ops are only accepted in IDLE.
    always_ff @(posedge clk) begin
        if (flush_en)      valid[flush_idx] <= 1'b0;
        else if (clr_en)   valid[wr_idx]    <= 1'b0;
        else if (alloc_en) valid[wr_idx]    <= 1'b1;
    end

endmodule

// File: rtl/l2_cache_assoc.sv
// ---------------------------------------------------------------------------
// l2_cache_assoc
// Parametrised set-associative word-granular L2 cache.
//   CLK, nRES           : clock, async active-low reset (starts a flush)
//   RDA -> Match, RDD   : registered lookup, latency 1
//   Busy                : flush engine active, all lookups miss
//   WRA, WRD, WRM       : write-side address, data, byte mask
//   TS, WR, CLR, ALL    : fill, write snoop, invalidate, flush-all strobes,
//                         qualified by CPUCLKr and ignored while Busy
// ---------------------------------------------------------------------------
module l2_cache_assoc
    import l2_cache_pkg::*;
#(
    parameter int WAYS     = 8,
    parameter int SET_BITS = 6,
    parameter int ADDR_HI  = 27
) (
    input  logic                          CLK,
    input  logic                          nRES,
    input  logic                          CPUCLKr,
    input  logic [addr_width(ADDR_HI)-1:0] RDA,
    output logic [31:0]                   RDD,
    output logic                          Match,
    output logic                          Busy,
    input  logic [addr_width(ADDR_HI)-1:0] WRA,
    input  logic [31:0]                   WRD,
    input  logic [3:0]                    WRM,
    input  logic                          TS,
    input  logic                          WR,
    input  logic                          CLR,
    input  logic                          ALL
);

    localparam int TAG_W = tag_width(ADDR_HI, SET_BITS);
    localparam int SETS  = 1 << SET_BITS;
    localparam int WAY_W = $clog2(WAYS);

    logic [SET_BITS-1:0] rd_idx, wr_idx, flush_cnt;
    logic [TAG_W-1:0]    rd_tag, wr_tag;
    state_t              state;
    wr_op_t              op;
    logic [WAY_W-1:0]    rr_ptr [SETS];
    logic [WAY_W-1:0]    victim;
    logic                use_rr, alloc, hit_any;
    logic [31:0]         hit_data;
    logic [WAYS-1:0]     rd_hit, wr_hit, wr_valid;
    logic [31:0]         rd_data [WAYS];

    assign rd_idx = RDA[SET_BITS-1:0];
    assign rd_tag = RDA[ADDR_HI-2:SET_BITS];
    assign wr_idx = WRA[SET_BITS-1:0];
    assign wr_tag = WRA[ADDR_HI-2:SET_BITS];

    assign op    = (CPUCLKr && state == ST_IDLE) ? decode_op(TS, WR, CLR, ALL) : OP_NONE;
    assign alloc = (op == OP_FILL) && !(|wr_hit) && (WRM == 4'hF);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        l2_cache_assoc_way #(
            .SET_BITS (SET_BITS),
            .TAG_W    (TAG_W)
        ) u_way (
            .clk       (CLK),
            .rd_idx    (rd_idx),
            .rd_tag    (rd_tag),
            .rd_hit    (rd_hit[w]),
            .rd_data   (rd_data[w]),
            .wr_idx    (wr_idx),
            .wr_tag    (wr_tag),
            .wr_data   (WRD),
            .wr_mask   (WRM),
            .merge_en  ((op == OP_FILL || op == OP_WRITE) && wr_hit[w]),
            .alloc_en  (alloc && victim == WAY_W'(w)),
            .clr_en    ((op == OP_CLR) && wr_hit[w]),
            .flush_en  (state == ST_FLUSH),
            .flush_idx (flush_cnt),
            .wr_hit    (wr_hit[w]),
            .wr_valid  (wr_valid[w])
        );
    end

    // NOTE: every variable driven here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    // Descending scans let the lowest-numbered way win.
    always_comb begin
        victim = rr_ptr[wr_idx];
        use_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!wr_valid[w]) begin
                victim = WAY_W'(w);
                use_rr = 1'b0;
            end
        end
    end

    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_hit[w]) begin
                hit_any  = 1'b1;
                hit_data = rd_data[w];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            Match <= 1'b0;
            RDD   <= '0;
        end else begin
            Match <= hit_any && state == ST_IDLE;
            RDD   <= (state == ST_IDLE) ? hit_data : '0;
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            Busy      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op == OP_FLUSH_ALL) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                        Busy      <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == SET_BITS'(SETS - 1)) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_FLUSH;
                    Busy  <= 1'b1;
                end
            endcase
        end
    end

    // The pointer advances only when it actually chose the victim; WAYS is a
    // power of two so the natural wrap gives mod WAYS.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (alloc && use_rr) begin
            rr_ptr[wr_idx] <= rr_ptr[wr_idx] + 1'b1;
        end
    end

endmodule
